// File: rtl/demux8_pkg.sv
// Shared constants and state encoding for the demux8_collect receive-side deserialiser.
package demux8_pkg;

  localparam int DEMUX8_LANES  = 8;
  localparam int DEMUX8_ADDR_W = 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_SCAN = SCAN,
    ST_DONE = DONE
  } demux8_state_e;

endpackage

// File: rtl/demux8_lane_dec.sv
// Combinational binary-to-one-hot lane decoder; output is all zero when en is low.
module demux8_lane_dec
  import demux8_pkg::*;
#(
  parameter int LANES  = DEMUX8_LANES,
  parameter int ADDR_W = DEMUX8_ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  output logic [LANES-1:0]  onehot
);

  // One-hot select gated by the enable (the serial data bit in practice)
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end else begin
      onehot = '0;
    end
  end

endmodule

// File: rtl/demux8_collect.sv
// Drives the 8:1 mux select, samples its serial bit per lane and reassembles the word.
// Optional macro DEMUX8_COLLECT_PARITY_EN adds a registered parity_out of each completed word.
module demux8_collect
  import demux8_pkg::*;
#(
  parameter int LANES  = DEMUX8_LANES,
  parameter int ADDR_W = DEMUX8_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic              d_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic              busy,
  output logic [LANES-1:0]  demux_out,
  output logic [LANES-1:0]  word_out,
  output logic              word_valid
`ifdef DEMUX8_COLLECT_PARITY_EN
  ,
  output logic              parity_out
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LANES - 1);

  demux8_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic [LANES-1:0]  demux_q, demux_d;
  logic [LANES-1:0]  word_q, word_d;
  logic              valid_q, valid_d;
  logic [LANES-1:0]  buf_q, buf_d;
  logic              parity_q, parity_d;
  logic [LANES-1:0]  lane_dec_s;

  demux8_lane_dec #(
    .LANES  (LANES),
    .ADDR_W (ADDR_W)
  ) u_lane_dec (
    .addr   (addr_q),
    .en     (d_in),
    .onehot (lane_dec_s)
  );

  // Next-state logic: scan sequencing, lane sampling and word assembly
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    busy_d   = busy_q;
    demux_d  = demux_q;
    word_d   = word_q;
    valid_d  = valid_q;
    buf_d    = buf_q;
    parity_d = parity_q;
    case (state_q)
      ST_IDLE: begin
        addr_d  = '0;
        demux_d = '0;
        valid_d = 1'b0;
        if (start) begin
          state_d = ST_SCAN;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_SCAN: begin
        if (en) begin
          buf_d[addr_q] = d_in;
          demux_d       = lane_dec_s;
          if (addr_q == LAST_ADDR) begin
            // Final lane comes straight from d_in; the buffer holds lanes 0..LANES-2
            word_d   = {d_in, buf_q[LANES-2:0]};
            parity_d = ^{d_in, buf_q[LANES-2:0]};
            valid_d  = 1'b1;
            busy_d   = 1'b0;
            addr_d   = '0;
            state_d  = ST_DONE;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_DONE: begin
        valid_d = 1'b0;
        demux_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        addr_d  = '0;
        busy_d  = 1'b0;
        demux_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      demux_q  <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      buf_q    <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      demux_q  <= demux_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
      buf_q    <= buf_d;
      parity_q <= parity_d;
    end
  end

  assign addr_out   = addr_q;
  assign busy       = busy_q;
  assign demux_out  = demux_q;
  assign word_out   = word_q;
  assign word_valid = valid_q;

`ifdef DEMUX8_COLLECT_PARITY_EN
  assign parity_out = parity_q;
`else
  logic unused_parity_s;
  assign unused_parity_s = parity_q;
`endif

endmodule

// File: tb/tb_demux8_collect.sv
// Scoreboard bench for demux8_collect: a model mux feeds d_in, completed words are checked by a monitor.
module tb_demux8_collect;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       start;
  logic       d_in;
  logic [2:0] addr_out;
  logic       busy;
  logic [7:0] demux_out;
  logic [7:0] word_out;
  logic       word_valid;
`ifdef DEMUX8_COLLECT_PARITY_EN
  logic       parity_out;
`endif

  logic [7:0] mux_word = 8'h00;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  typedef struct {
    logic [7:0] w;
    int         at;
  } exp_t;
  exp_t exp_q[$];

  demux8_collect dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .start      (start),
    .d_in       (d_in),
    .addr_out   (addr_out),
    .busy       (busy),
    .demux_out  (demux_out),
    .word_out   (word_out),
    .word_valid (word_valid)
`ifdef DEMUX8_COLLECT_PARITY_EN
    ,
    .parity_out (parity_out)
`endif
  );

  always #5 clk = ~clk;

  // Model of the upstream combinational 8:1 mux
  assign d_in = mux_word[addr_out];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: each word_valid pulse must match the oldest outstanding scan
  always @(negedge clk) begin
    exp_t e;
    if (word_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(word_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("word_out", 32'(word_out), 32'(e.w));
        check("valid_cycle", 32'(cyc), 32'(e.at));
`ifdef DEMUX8_COLLECT_PARITY_EN
        check("parity_out", 32'(parity_out), 32'(^e.w));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_scan(input logic [7:0] w, input int stall_at, input int stall_len,
                          input bit poke_done);
    logic [7:0] held;
    mux_word = w;
    start    = 1'b1;
    en       = 1'b1;
    exp_q.push_back('{w, cyc + 9 + stall_len});
    tick();
    start = 1'b0;
    check("busy_scan", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("addr_seq", 32'(addr_out), 32'(i));
      if (i == stall_at) begin
        held = demux_out;
        en   = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          tick();
          check("addr_stall", 32'(addr_out), 32'(i));
          check("demux_stall", 32'(demux_out), 32'(held));
        end
        en = 1'b1;
      end
      tick();
      check("demux_route", 32'(demux_out), w[i] ? (32'd1 << i) : 32'd0);
    end
    check("addr_wrap", 32'(addr_out), 32'd0);
    check("busy_done", 32'(busy), 32'd0);
    if (poke_done) start = 1'b1;
    tick();
    start = 1'b0;
    check("demux_idle", 32'(demux_out), 32'd0);
    check("word_hold", 32'(word_out), 32'(w));
    tick();
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] rw;
    int         sa;
    int         sl;
    rst   = 1'b1;
    en    = 1'b0;
    start = 1'b0;
    tick();
    tick();
    check("rst_addr", 32'(addr_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_demux", 32'(demux_out), 32'd0);
    check("rst_word", 32'(word_out), 32'd0);
    check("rst_valid", 32'(word_valid), 32'd0);
    rst = 1'b0;
    tick();

    run_scan(8'hA5, 8, 0, 1'b0);
    run_scan(8'h3C, 3, 4, 1'b0);
    run_scan(8'h01, 8, 0, 1'b0);
    run_scan(8'h80, 8, 0, 1'b1);
    run_scan(8'h07, 8, 0, 1'b0);
    run_scan(8'h03, 8, 0, 1'b0);

    // Back-to-back scans with start held high
    mux_word = 8'h55;
    start    = 1'b1;
    en       = 1'b1;
    exp_q.push_back('{8'h55, cyc + 9});
    exp_q.push_back('{8'hAA, cyc + 19});
    repeat (9) tick();
    mux_word = 8'hAA;
    repeat (10) tick();
    start = 1'b0;
    tick();
    tick();
    check("b2b_idle", 32'(busy), 32'd0);

    // Reset in the middle of a scan after three samples
    mux_word = 8'hFF;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("pre_rst_addr", 32'(addr_out), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_addr", 32'(addr_out), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_demux", 32'(demux_out), 32'd0);
    check("midrst_word", 32'(word_out), 32'd0);
    check("midrst_valid", 32'(word_valid), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_idle", 32'(busy), 32'd0);
    run_scan(8'hFF, 8, 0, 1'b0);

    // Randomised words and stalls
    for (int n = 0; n < 16; n++) begin
      rw = 8'($urandom);
      sa = $urandom_range(0, 8);
      sl = (sa == 8) ? 0 : $urandom_range(1, 5);
      run_scan(rw, sa, sl, 1'($urandom_range(0, 1)));
    end

    tick();
    check("pending_words", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
